// File: rtl/photonic_ctrl_arbiter_pkg.sv
// Shared packet and state definitions for the photonic control-plane arbiter.
package photonic_ctrl_pkg;

    typedef enum logic [3:0] {
        PKT_IDLE    = 4'd0,
        PKT_REQ     = 4'd1,
        PKT_GRANT   = 4'd2,
        PKT_RELEASE = 4'd3,
        PKT_DENY    = 4'd4,
        PKT_REVOKE  = 4'd5
    } pkt_type_e;

    localparam int TYPE_MSB = 31;
    localparam int TYPE_LSB = 28;
    localparam int RSVD_MSB = 27;
    localparam int RSVD_LSB = 16;
    localparam int DEST_MSB = 15;
    localparam int DEST_LSB = 0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PEND    = 2'd1,
        S_GRANTED = 2'd2
    } src_state_e;

    function automatic logic [31:0] make_pkt(pkt_type_e t, logic [15:0] dest);
        logic [31:0] p;
        p = '0;
        p[TYPE_MSB:TYPE_LSB] = t;
        p[DEST_MSB:DEST_LSB] = dest;
        return p;
    endfunction

endpackage

// File: rtl/photonic_ctrl_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_picker #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant_oh,
    output logic          valid
);

    logic [PW-1:0] idx;

    always_comb begin
        grant_oh = '0;
        valid    = 1'b0;
        idx      = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!valid && req[idx]) begin
                grant_oh[idx] = 1'b1;
                valid         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/photonic_ctrl_arbiter.sv
// Control-plane arbiter granting exclusive destination receive channels round-robin.
// Optional grant revocation after TIMEOUT cycles is enabled by defining GRANT_TIMEOUT_EN.
module photonic_ctrl_arbiter
    import photonic_ctrl_pkg::*;
#(
    parameter int NODES   = 4,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       ctrl_in_packet  [NODES],
    output logic [31:0]       ctrl_out_packet [NODES],
    output logic [NODES-1:0]  dest_busy,
    output logic [NODES-1:0]  grant_active
);

    localparam int PW = (NODES > 1) ? $clog2(NODES) : 1;

    src_state_e        state_q [NODES];
    src_state_e        state_d [NODES];
    logic [PW-1:0]     dest_q  [NODES];
    logic [PW-1:0]     dest_d  [NODES];
    logic [31:0]       out_q   [NODES];
    logic [31:0]       out_d   [NODES];
    logic [PW-1:0]     rr_q, rr_d;
    logic [NODES-1:0]  busy_q, busy_d;
    logic [NODES-1:0]  gact_q, gact_d;

    logic [3:0]        in_type [NODES];
    logic [15:0]       in_dest [NODES];
    logic [NODES-1:0]  rsvd_unused;
    logic [NODES-1:0]  deny_now, release_ok, timeout_now, busy_eff, eligible, win_oh;
    logic              win_valid;

`ifdef GRANT_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0]     cnt_q [NODES];
    logic [CW-1:0]     cnt_d [NODES];
`endif

    for (genvar g = 0; g < NODES; g++) begin : g_port
        assign in_type[g]         = ctrl_in_packet[g][TYPE_MSB:TYPE_LSB];
        assign in_dest[g]         = ctrl_in_packet[g][DEST_MSB:DEST_LSB];
        assign rsvd_unused[g]     = ^ctrl_in_packet[g][RSVD_MSB:RSVD_LSB];
        assign ctrl_out_packet[g] = out_q[g];
    end

    assign dest_busy    = busy_q;
    assign grant_active = gact_q;

    // Releases and revocations free their destination before this cycle's arbitration.
    always_comb begin
        deny_now    = '0;
        release_ok  = '0;
        timeout_now = '0;
        busy_eff    = '0;
        eligible    = '0;
        for (int s = 0; s < NODES; s++) begin
            deny_now[s]   = (in_type[s] == PKT_REQ) &&
                            ((in_dest[s] >= 16'(NODES)) || (in_dest[s] == 16'(s)));
            release_ok[s] = (in_type[s] == PKT_RELEASE) && (state_q[s] == S_GRANTED) &&
                            (in_dest[s] == 16'(dest_q[s]));
`ifdef GRANT_TIMEOUT_EN
            timeout_now[s] = (state_q[s] == S_GRANTED) && (cnt_q[s] == CW'(TIMEOUT - 1)) &&
                             !release_ok[s] && !deny_now[s];
`endif
            if ((state_q[s] == S_GRANTED) && !release_ok[s] && !timeout_now[s])
                busy_eff[dest_q[s]] = 1'b1;
        end
        // A DENY going out this cycle displaces the grant, so that source sits out one round.
        for (int s = 0; s < NODES; s++)
            eligible[s] = (state_q[s] == S_PEND) && !busy_eff[dest_q[s]] && !deny_now[s];
    end

    rr_picker #(.N(NODES), .PW(PW)) u_picker (
        .req      (eligible),
        .ptr      (rr_q),
        .grant_oh (win_oh),
        .valid    (win_valid)
    );

    always_comb begin
        rr_d   = rr_q;
        busy_d = '0;
        gact_d = '0;
        for (int s = 0; s < NODES; s++) begin
            state_d[s] = state_q[s];
            dest_d[s]  = dest_q[s];
            out_d[s]   = make_pkt(PKT_IDLE, 16'h0);
`ifdef GRANT_TIMEOUT_EN
            cnt_d[s]   = cnt_q[s];
`endif
            if (deny_now[s])
                out_d[s] = make_pkt(PKT_DENY, in_dest[s]);
            case (state_q[s])
                S_IDLE: begin
                    if ((in_type[s] == PKT_REQ) && !deny_now[s]) begin
                        state_d[s] = S_PEND;
                        dest_d[s]  = in_dest[s][PW-1:0];
                    end
                end
                S_PEND: begin
                    if (win_valid && win_oh[s]) begin
                        state_d[s] = S_GRANTED;
                        out_d[s]   = make_pkt(PKT_GRANT, 16'(dest_q[s]));
                        rr_d       = (s == NODES - 1) ? '0 : PW'(s + 1);
`ifdef GRANT_TIMEOUT_EN
                        cnt_d[s]   = '0;
`endif
                    end
                end
                S_GRANTED: begin
                    if (release_ok[s]) begin
                        state_d[s] = S_IDLE;
                    end else if (timeout_now[s]) begin
                        state_d[s] = S_IDLE;
                        out_d[s]   = make_pkt(PKT_REVOKE, 16'(dest_q[s]));
                    end
`ifdef GRANT_TIMEOUT_EN
                    else if (cnt_q[s] != CW'(TIMEOUT - 1)) begin
                        cnt_d[s] = cnt_q[s] + 1'b1;
                    end
`endif
                end
                default: state_d[s] = S_IDLE;
            endcase
            if (state_d[s] == S_GRANTED) begin
                busy_d[dest_d[s]] = 1'b1;
                gact_d[s]         = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q   <= '0;
            busy_q <= '0;
            gact_q <= '0;
            for (int s = 0; s < NODES; s++) begin
                state_q[s] <= S_IDLE;
                dest_q[s]  <= '0;
                out_q[s]   <= 32'h0;
`ifdef GRANT_TIMEOUT_EN
                cnt_q[s]   <= '0;
`endif
            end
        end else begin
            rr_q   <= rr_d;
            busy_q <= busy_d;
            gact_q <= gact_d;
            for (int s = 0; s < NODES; s++) begin
                state_q[s] <= state_d[s];
                dest_q[s]  <= dest_d[s];
                out_q[s]   <= out_d[s];
`ifdef GRANT_TIMEOUT_EN
                cnt_q[s]   <= cnt_d[s];
`endif
            end
        end
    end

endmodule
